state_countdown: RTL and testbench
==================================

STATE_COUNTDOWN -- requirements
Module: state_countdown

Interface
REQ-001 SHALL have parameter stateID, default 2, the currentState code in which this block is active.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port currentState  input  3  global mode code from the mode controller.
REQ-005 SHALL have port loadValue  input  16  preset {min[15:8], sec[7:0]}, each field binary, from the programming stage.
REQ-006 SHALL have port tick  input  1  one-cycle 1 Hz pulse, already synchronized.
REQ-007 SHALL have port toggle  input  1  one-cycle pause/resume pulse, already synchronized.
REQ-008 SHALL have port increase  input  1  one-cycle add-minute pulse, already synchronized.
REQ-009 SHALL have port digitsOut  output  16  remaining time {min, sec}, each field binary 0-59.
REQ-010 SHALL have port running  output  1  high while counting.
REQ-011 SHALL have port finished  output  1  high while expired, until the block is left.

Function
REQ-012 SHALL register currentState each cycle (prevState) and treat entry as currentState==stateID && prevState!=stateID.
REQ-013 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-014 On entry, from any state: min/sec load from loadValue with each field clamped to 59 if >59; go to RUN; finished<=0.
REQ-015 On entry with a loaded value of 00:00: go to DONE one cycle after the load; finished=1 from that cycle.
REQ-016 While currentState!=stateID: go to IDLE; running=0, finished=0; min/sec hold their values.
REQ-017 In RUN, on tick with toggle=0: sec>0 -> sec-1; sec==0 && min>0 -> min-1, sec<=59.
REQ-018 In RUN, a tick that brings the value to 00:00: go to DONE on the same edge, with finished=1 on that edge.
REQ-019 In RUN, on toggle: go to PAUSED with no decrement, even if tick is high in the same cycle.
REQ-020 In PAUSED, on toggle: go to RUN; tick is ignored.
REQ-021 In PAUSED, on increase: min<=min+1, saturating at 59; sec unchanged; increase is ignored in all other states.
REQ-022 In PAUSED, with toggle and increase in the same cycle: apply both the increment and the resume.
REQ-023 In DONE: value holds 00:00; tick, toggle and increase are ignored; only exit or re-entry leaves DONE.
REQ-024 running SHALL be 1 exactly when the state is RUN; finished SHALL be 1 exactly when the state is DONE.
REQ-025 digitsOut SHALL equal {min, sec} combinationally from registers, with zero latency after the edge.
REQ-026 Arithmetic SHALL be 8-bit unsigned per field; a field SHALL never exceed 59 or underflow below 0.

Reset
REQ-027 While rst_n=0, the block SHALL be held asynchronously at: state IDLE, min=0, sec=0, prevState=0, running=0, finished=0, digitsOut=16'h0000.
REQ-028 Reset deassertion SHALL take effect on the next clk edge.
REQ-029 If currentState==stateID at the first edge after deassertion, it SHALL count as entry (prevState=0), provided stateID!=0.
REQ-030 Reset asserted mid-RUN SHALL abort the count immediately with no further decrements.

Verification
REQ-031 Load {1,5}, enter state 2, apply 6 ticks -> digitsOut {0,59}, running=1; 59 more ticks -> {0,0}, finished=1, running=0 on the same edge.
REQ-032 Load {0,0}, enter -> finished=1 one cycle after entry; further ticks leave digitsOut=0.
REQ-033 Load {2,10}, toggle and tick in the same cycle -> PAUSED, value {2,10}; 3 ticks -> unchanged; increase ×60 -> min=59; toggle -> running=1.
REQ-034 Load {70,99} -> digitsOut {59,59}.
REQ-035 Mid-RUN at {0,30}, currentState->1 -> running=0, value held {0,30}; currentState->2 with loadValue {0,3} -> reload to {0,3}, RUN.
REQ-036 Assert rst_n=0 mid-RUN between clock edges -> outputs zero immediately without a clk edge; after release with currentState=2 -> loads loadValue.

Source files
------------

// File: rtl/state_countdown.sv
// Countdown timer active while currentState equals stateID: loads a clamped
// min:sec preset on entry, counts down on tick, and supports pause/resume and add-minute.
module state_countdown #(
  parameter logic [2:0] stateID = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  currentState,
  input  logic [15:0] loadValue,
  input  logic        tick,
  input  logic        toggle,
  input  logic        increase,
  output logic [15:0] digitsOut,
  output logic        running,
  output logic        finished
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t     state;
  logic [2:0] prev_state;
  logic [7:0] min, sec;
  logic       active, entry;

  function automatic logic [7:0] clamp59(input logic [7:0] v);
    return (v > 8'd59) ? 8'd59 : v;
  endfunction

  assign active    = (currentState == stateID);
  assign entry     = active && (prev_state != stateID);
  assign digitsOut = {min, sec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_state <= 3'd0;
      min        <= 8'd0;
      sec        <= 8'd0;
      running    <= 1'b0;
      finished   <= 1'b0;
    end else begin
      prev_state <= currentState;
      if (!active) begin
        state    <= IDLE;
        running  <= 1'b0;
        finished <= 1'b0;
      end else if (entry) begin
        min      <= clamp59(loadValue[15:8]);
        sec      <= clamp59(loadValue[7:0]);
        state    <= RUN;
        running  <= 1'b1;
        finished <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            // A zero preset sits in RUN for one cycle before expiring here
            if (min == 8'd0 && sec == 8'd0) begin
              state    <= DONE;
              running  <= 1'b0;
              finished <= 1'b1;
            end else if (toggle) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              if (sec != 8'd0) begin
                sec <= sec - 8'd1;
                if (min == 8'd0 && sec == 8'd1) begin
                  state    <= DONE;
                  running  <= 1'b0;
                  finished <= 1'b1;
                end
              end else begin
                min <= min - 8'd1;
                sec <= 8'd59;
              end
            end
          end
          PAUSED: begin
            if (increase && min < 8'd59) min <= min + 8'd1;
            if (toggle) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            running  <= 1'b0;
            finished <= 1'b1;
          end
          default: begin
            running  <= 1'b0;
            finished <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_state_countdown.sv
// Directed self-checking bench for state_countdown (stateID = 2).
module tb_state_countdown;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  currentState;
  logic [15:0] loadValue;
  logic        tick, toggle, increase;
  logic [15:0] digitsOut;
  logic        running, finished;

  int n_checks = 0;
  int n_fail   = 0;

  state_countdown #(.stateID(3'd2)) dut (
    .clk(clk), .rst_n(rst_n), .currentState(currentState), .loadValue(loadValue),
    .tick(tick), .toggle(toggle), .increase(increase),
    .digitsOut(digitsOut), .running(running), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d, input logic r, input logic f);
    check({tag, ".digits"}, digitsOut, d);
    check({tag, ".running"}, {15'd0, running}, {15'd0, r});
    check({tag, ".finished"}, {15'd0, finished}, {15'd0, f});
  endtask

  initial begin
    rst_n = 1'b0; currentState = 3'd0; loadValue = 16'h0000;
    tick = 1'b0; toggle = 1'b0; increase = 1'b0;
    #3;
    check_all("reset", 16'h0000, 1'b0, 1'b0);
    #9 rst_n = 1'b1;
    step();
    check_all("idle", 16'h0000, 1'b0, 1'b0);

    // Basic countdown 1:05 -> 0:00
    loadValue = {8'd1, 8'd5}; currentState = 3'd2;
    step();
    check_all("load105", 16'h0105, 1'b1, 1'b0);
    tick = 1'b1;
    repeat (6) step();
    check_all("six_ticks", 16'h003B, 1'b1, 1'b0);
    repeat (58) step();
    check_all("one_left", 16'h0001, 1'b1, 1'b0);
    step();
    check_all("expire", 16'h0000, 1'b0, 1'b1);
    step();
    check_all("done_tick", 16'h0000, 1'b0, 1'b1);
    tick = 1'b0;

    // Zero preset expires one cycle after entry
    currentState = 3'd1;
    step();
    check_all("leave", 16'h0000, 1'b0, 1'b0);
    loadValue = 16'h0000; currentState = 3'd2;
    step();
    check_all("zero_load", 16'h0000, 1'b1, 1'b0);
    step();
    check_all("zero_done", 16'h0000, 1'b0, 1'b1);
    tick = 1'b1; toggle = 1'b1; increase = 1'b1;
    step();
    check_all("done_ignore", 16'h0000, 1'b0, 1'b1);
    tick = 1'b0; toggle = 1'b0; increase = 1'b0;

    // Pause / increase / resume
    currentState = 3'd1;
    step();
    loadValue = {8'd2, 8'd10}; currentState = 3'd2;
    step();
    check_all("load210", 16'h020A, 1'b1, 1'b0);
    increase = 1'b1;
    step();
    check_all("inc_in_run", 16'h020A, 1'b1, 1'b0);
    increase = 1'b0; toggle = 1'b1; tick = 1'b1;
    step();
    check_all("pause_tick", 16'h020A, 1'b0, 1'b0);
    toggle = 1'b0;
    repeat (3) step();
    check_all("paused_ticks", 16'h020A, 1'b0, 1'b0);
    tick = 1'b0; increase = 1'b1;
    step();
    check_all("inc1", 16'h030A, 1'b0, 1'b0);
    toggle = 1'b1;
    step();
    check_all("inc_resume", 16'h040A, 1'b1, 1'b0);
    increase = 1'b0;
    step();
    check_all("repause", 16'h040A, 1'b0, 1'b0);
    toggle = 1'b0; increase = 1'b1;
    repeat (60) step();
    check_all("inc_sat", 16'h3B0A, 1'b0, 1'b0);
    increase = 1'b0; toggle = 1'b1;
    step();
    check_all("resume", 16'h3B0A, 1'b1, 1'b0);
    toggle = 1'b0; tick = 1'b1;
    step();
    check_all("resume_tick", 16'h3B09, 1'b1, 1'b0);
    tick = 1'b0;

    // Clamp out-of-range preset
    currentState = 3'd1;
    step();
    loadValue = {8'd70, 8'd99}; currentState = 3'd2;
    step();
    check_all("clamp", 16'h3B3B, 1'b1, 1'b0);

    // Leave mid-run, hold, re-enter with a new preset
    currentState = 3'd1;
    step();
    loadValue = {8'd0, 8'd35}; currentState = 3'd2;
    step();
    check_all("load035", 16'h0023, 1'b1, 1'b0);
    tick = 1'b1;
    repeat (5) step();
    check_all("at030", 16'h001E, 1'b1, 1'b0);
    currentState = 3'd1;
    step();
    check_all("exit_hold", 16'h001E, 1'b0, 1'b0);
    tick = 1'b0; loadValue = {8'd0, 8'd3}; currentState = 3'd2;
    step();
    check_all("reload", 16'h0003, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    tick = 1'b1;
    step();
    check_all("pre_reset", 16'h0002, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 1'b0, 1'b0);
    tick = 1'b0; loadValue = {8'd0, 8'd7};
    #3 rst_n = 1'b1;
    step();
    check_all("post_reset_entry", 16'h0007, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
